// File: rtl/nv_ram_rwsp_128x11_fifo_ctrl_if.sv
// Valid/ready FIFO bus and RAM-port bundle for the 128x11 FIFO controller.
// slave is the controller side; master is the user/RAM side.
interface nv_ram_rwsp_128x11_fifo_ctrl_if #(
   parameter int AW = 7,
   parameter int DW = 11
);
   logic          clr;
   logic          wr_pvld;
   logic          wr_prdy;
   logic [DW-1:0] wr_pd;
   logic          rd_pvld;
   logic          rd_prdy;
   logic [7:0]    occupancy;
   logic [AW-1:0] ram_wa;
   logic          ram_we;
   logic [DW-1:0] ram_di;
   logic [AW-1:0] ram_ra;
   logic          ram_re;
   logic          ram_ore;

   modport master (
      output clr, wr_pvld, wr_pd, rd_prdy,
      input  wr_prdy, rd_pvld, occupancy,
      input  ram_wa, ram_we, ram_di,
      input  ram_ra, ram_re, ram_ore
   );

   modport slave (
      input  clr, wr_pvld, wr_pd, rd_prdy,
      output wr_prdy, rd_pvld, occupancy,
      output ram_wa, ram_we, ram_di,
      output ram_ra, ram_re, ram_ore
   );
endinterface

// File: rtl/nv_ram_rwsp_128x11_fifo_ctrl.sv
// FIFO sequencer for a 128x11 two-port RAM with a registered read
// address (re) and an output register (ore); rd data is the RAM dout.
module nv_ram_rwsp_128x11_fifo_ctrl #(
   parameter int DEPTH = 128,
   parameter int AW    = 7,
   parameter int DW    = 11
) (
   input logic clk,
   input logic rst,
   nv_ram_rwsp_128x11_fifo_ctrl_if.slave bus
);

   localparam logic [7:0] FULL = 8'(DEPTH);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [7:0]    r_occ;
   logic [7:0]    r_unissued;
   logic          r_a_vld;
   logic          r_b_vld;

   logic          w_wr_prdy;
   logic          w_accept;
   logic          w_b_load;
   logic          w_issue;
   logic          w_pop;
   logic [DW-1:0] w_wr_pd;

   // Write port depends only on registered occupancy, clr and reset.
   assign w_wr_prdy = !rst && !bus.clr && (r_occ != FULL);
   assign w_accept  = bus.wr_pvld && w_wr_prdy;

   // Stage B (dout_r) refills when empty or being consumed.
   assign w_b_load  = r_a_vld && (!r_b_vld || bus.rd_prdy) && !bus.clr;

   // Stage A (ra_d) takes a new address only when it is free or draining.
   assign w_issue   = (r_unissued != 8'd0)
                   && (!r_a_vld || w_b_load) && !bus.clr;

   assign w_pop     = r_b_vld && bus.rd_prdy;
   assign w_wr_pd   = bus.wr_pd;

   assign bus.wr_prdy   = w_wr_prdy;
   assign bus.rd_pvld   = r_b_vld;
   assign bus.occupancy = r_occ;
   assign bus.ram_we    = w_accept;
   assign bus.ram_wa    = r_wr_ptr;
   assign bus.ram_di    = w_wr_pd;
   assign bus.ram_re    = w_issue;
   assign bus.ram_ra    = r_rd_ptr;
   assign bus.ram_ore   = w_b_load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_occ      <= '0;
         r_unissued <= '0;
         r_a_vld    <= 1'b0;
         r_b_vld    <= 1'b0;
      end else if (bus.clr) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_occ      <= '0;
         r_unissued <= '0;
         r_a_vld    <= 1'b0;
         r_b_vld    <= 1'b0;
      end else begin
         if (w_accept)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_issue)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         r_occ      <= r_occ + 8'(w_accept) - 8'(w_pop);
         r_unissued <= r_unissued + 8'(w_accept) - 8'(w_issue);
         r_a_vld    <= w_issue || (r_a_vld && !w_b_load);
         r_b_vld    <= w_b_load || (r_b_vld && !bus.rd_prdy);
      end
   end

   // Every counted entry sits in exactly one place: unissued, ra_d or dout_r.
   a_occ_split: assert property (@(posedge clk) disable iff (rst)
      r_occ == r_unissued + {7'd0, r_a_vld} + {7'd0, r_b_vld});

   a_occ_bound: assert property (@(posedge clk) disable iff (rst)
      r_occ <= FULL);

endmodule

// File: tb/tb_nv_ram_rwsp_128x11_fifo_ctrl.sv
// Bench for the 128x11 FIFO controller: RAM model, queue reference,
// directed vector table and randomized traffic.
module tb_nv_ram_rwsp_128x11_fifo_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nv_ram_rwsp_128x11_fifo_ctrl_if #(.AW(7), .DW(11)) bus ();

   nv_ram_rwsp_128x11_fifo_ctrl #(.DEPTH(128), .AW(7), .DW(11)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural RAM: registered read address, output register.
   bit [10:0] mem [128];
   bit [6:0]  ra_d;
   bit [10:0] dout_r;
   always @(posedge clk) begin
      if (bus.ram_we)  mem[bus.ram_wa] <= bus.ram_di;
      if (bus.ram_re)  ra_d <= bus.ram_ra;
      if (bus.ram_ore) dout_r <= mem[ra_d];
   end

   typedef struct {
      bit [10:0] d;
      int        t;
   } ent_t;

   ent_t q[$];
   int   cyc = 0;
   int   n_push = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   ra_live = 0;
   bit   dout_live = 0;

   typedef struct {
      bit        wv;
      bit [10:0] wd;
      bit        rp;
      bit        e_wprdy;
      bit        e_pvld;
      int        e_occ;
      bit        e_we;
      bit        e_re;
      bit        e_ore;
      int        e_dout;
   } vec_t;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at cycle %0d",
                    nm, act, exp, cyc);
   endtask

   function automatic bit exp_wrprdy();
      return !rst && !bus.clr && (q.size() != 128);
   endfunction

   // Head is visible once two edges have passed since its write.
   function automatic bit exp_pvld();
      return (q.size() > 0) && (q[0].t + 2 <= cyc);
   endfunction

   task automatic drive(bit wv, bit [10:0] wd, bit rp, bit c);
      bus.wr_pvld = wv;
      bus.wr_pd   = wd;
      bus.rd_prdy = rp;
      bus.clr     = c;
      #1;
   endtask

   task automatic model_check();
      bit ep;
      ep = exp_pvld();
      chk("wr_prdy", int'(bus.wr_prdy), int'(exp_wrprdy()));
      chk("ram_we", int'(bus.ram_we), int'(bus.wr_pvld && exp_wrprdy()));
      chk("occupancy", int'(bus.occupancy), q.size());
      chk("rd_pvld", int'(bus.rd_pvld), int'(ep));
      if (ep) chk("rd_data", int'(dout_r), int'(q[0].d));
      if (bus.ram_we) chk("ram_di", int'(bus.ram_di), int'(bus.wr_pd));
      if (bus.ram_ore) chk("ore_src_live", int'(ra_live), 1);
      if (bus.ram_ore && dout_live)
         chk("ore_overwrite", int'(bus.rd_prdy), 1);
      if (bus.ram_re && ra_live)
         chk("re_overwrite", int'(bus.ram_ore), 1);
      if (bus.ram_re)
         chk("re_spec", int'(q.size() > int'(ra_live) + int'(dout_live)), 1);
      if (bus.clr || rst) begin
         chk("clr_re", int'(bus.ram_re), 0);
         chk("clr_ore", int'(bus.ram_ore), 0);
      end
   endtask

   task automatic advance();
      bit acc, pop, re, ore, lpop, r, c;
      bit [10:0] d;
      ent_t e;
      acc  = bus.wr_pvld && exp_wrprdy();
      pop  = exp_pvld() && bus.rd_prdy;
      d    = bus.wr_pd;
      re   = bus.ram_re;
      ore  = bus.ram_ore;
      lpop = bus.rd_pvld && bus.rd_prdy;
      r    = rst;
      c    = bus.clr;
      @(posedge clk);
      cyc++;
      if (r || c) begin
         q.delete();
         ra_live   = 0;
         dout_live = 0;
      end else begin
         if (pop) q.delete(0);
         if (acc) begin
            e.d = d;
            e.t = cyc;
            q.push_back(e);
            n_push++;
         end
         dout_live = ore || (dout_live && !lpop);
         ra_live   = re || (ra_live && !ore);
      end
      @(negedge clk);
   endtask

   task automatic step(bit wv, bit [10:0] wd, bit rp, bit c);
      drive(wv, wd, rp, c);
      model_check();
      advance();
   endtask

   task automatic drain(int budget);
      for (int i = 0; i < budget && q.size() > 0; i++)
         step(1'b0, 11'h0, 1'b1, 1'b0);
      chk("drain_empty", q.size(), 0);
   endtask

   vec_t vt[5];

   initial begin
      vt[0] = '{1, 11'h2AB, 0, 1, 0, 0, 1, 0, 0, -1};
      vt[1] = '{0, 11'h000, 0, 1, 0, 1, 0, 1, 0, -1};
      vt[2] = '{0, 11'h000, 0, 1, 0, 1, 0, 0, 1, -1};
      vt[3] = '{0, 11'h000, 1, 1, 1, 1, 0, 0, 0, 11'h2AB};
      vt[4] = '{0, 11'h000, 0, 1, 0, 0, 0, 0, 0, -1};

      // Power-on reset, with a push request already pending.
      rst = 1'b1;
      bus.wr_pvld = 1'b1;
      bus.wr_pd = 11'h123;
      bus.rd_prdy = 1'b0;
      bus.clr = 1'b0;
      #1;
      chk("rst_wr_prdy", int'(bus.wr_prdy), 0);
      chk("rst_we", int'(bus.ram_we), 0);
      chk("rst_rd_pvld", int'(bus.rd_pvld), 0);
      @(negedge clk);
      rst = 1'b0;
      bus.wr_pvld = 1'b0;
      #1;
      chk("rel_wr_prdy", int'(bus.wr_prdy), 1);
      chk("rel_occ", int'(bus.occupancy), 0);
      chk("rel_ram_wa", int'(bus.ram_wa), 0);
      chk("rel_ram_ra", int'(bus.ram_ra), 0);
      chk("rel_re_ore", int'(bus.ram_re || bus.ram_ore), 0);
      @(negedge clk);

      // Mid-stream reset at occupancy 5.
      for (int i = 0; i < 5; i++) step(1'b1, 11'(i + 1), 1'b0, 1'b0);
      chk("pre_rst_occ", int'(bus.occupancy), 5);
      rst = 1'b1;
      bus.wr_pvld = 1'b1;
      q.delete();
      #1;
      chk("mid_rst_occ", int'(bus.occupancy), 0);
      chk("mid_rst_pvld", int'(bus.rd_pvld), 0);
      chk("mid_rst_en",
          int'(bus.ram_we || bus.ram_re || bus.ram_ore), 0);
      advance();
      rst = 1'b0;

      // Directed latency vectors after reset release.
      foreach (vt[i]) begin
         drive(vt[i].wv, vt[i].wd, vt[i].rp, 1'b0);
         chk($sformatf("vec%0d_wr_prdy", i), int'(bus.wr_prdy),
             int'(vt[i].e_wprdy));
         chk($sformatf("vec%0d_rd_pvld", i), int'(bus.rd_pvld),
             int'(vt[i].e_pvld));
         chk($sformatf("vec%0d_occ", i), int'(bus.occupancy), vt[i].e_occ);
         chk($sformatf("vec%0d_we", i), int'(bus.ram_we), int'(vt[i].e_we));
         chk($sformatf("vec%0d_re", i), int'(bus.ram_re), int'(vt[i].e_re));
         chk($sformatf("vec%0d_ore", i), int'(bus.ram_ore),
             int'(vt[i].e_ore));
         if (vt[i].e_dout >= 0)
            chk($sformatf("vec%0d_dout", i), int'(dout_r), vt[i].e_dout);
         model_check();
         advance();
      end

      // Fill to full, refused 129th push, then pop-with-push at full.
      for (int i = 0; i < 128; i++) step(1'b1, 11'(i), 1'b0, 1'b0);
      chk("full_occ", int'(bus.occupancy), 128);
      step(1'b1, 11'h7FE, 1'b0, 1'b0);
      drive(1'b1, 11'h7FF, 1'b1, 1'b0);
      chk("full_pop_we", int'(bus.ram_we), 0);
      model_check();
      advance();
      chk("full_pop_occ", int'(bus.occupancy), 127);
      drive(1'b1, 11'h7FF, 1'b0, 1'b0);
      chk("reopen_we", int'(bus.ram_we), 1);
      model_check();
      advance();
      drain(400);

      // Streaming 300 words at full rate.
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 11'($urandom), 1'b1, 1'b0);
         chk("stream_occ_le3", int'(bus.occupancy <= 8'd3), 1);
      end
      drain(20);

      // Flush with stage B live and a push presented during clr.
      for (int i = 0; i < 10; i++) step(1'b1, 11'(i + 40), 1'b0, 1'b0);
      chk("pre_clr_pvld", int'(bus.rd_pvld), 1);
      drive(1'b1, 11'h3FF, 1'b0, 1'b1);
      chk("clr_we", int'(bus.ram_we), 0);
      model_check();
      advance();
      drive(1'b0, 11'h0, 1'b0, 1'b0);
      chk("post_clr_occ", int'(bus.occupancy), 0);
      chk("post_clr_pvld", int'(bus.rd_pvld), 0);
      advance();
      step(1'b1, 11'h155, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 11'h0, 1'b0, 1'b0);
      chk("flush_next_dout", int'(dout_r), 11'h155);
      drain(10);

      // Random traffic with 50% backpressure, 1000 accepted words.
      n_push = 0;
      for (int i = 0; i < 20000 && n_push < 1000; i++)
         step(1'($urandom % 2), 11'($urandom), 1'($urandom % 2), 1'b0);
      chk("random_pushes", n_push, 1000);
      drain(400);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
